excl_monitor: RTL

EXCL_MONITOR -- requirements
Module: excl_monitor

---
 rtl/excl_monitor.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/excl_monitor.sv
// excl_monitor
//   Watches CH channel pairs for an exclusivity violation: a[i] must never be
//   high together with b[i] delayed by DELAY cycles. It counts violations per
//   channel (saturating), raises a sticky error flag, and captures the lowest
//   channel index of the first violation.
//
//   State table
//     state  | meaning
//     IDLE   | disarmed; the b delay line keeps shifting, nothing is checked
//     WARMUP | armed; waits DELAY cycles so bd holds only post-arm samples
//     CHECK  | checking; no violation seen since arming or the last clr
//     FAULT  | checking continues after a violation, left only via clr or en=0
//
//   Ports
//     clk        in   sole clock, rising edge
//     rst_n      in   asynchronous active-low reset
//     en         in   arms checking; en=0 returns to IDLE from any state
//     clr        in   synchronous clear of counters, err and capture
//     a[CH]      in   per-channel "a" term
//     b[CH]      in   per-channel "b" term, compared after DELAY cycles
//     viol[CH]   out  registered per-channel violation pulse
//     err        out  sticky any-violation flag
//     first_vld  out  first_ch holds a captured index
//     first_ch   out  lowest channel index of the first violation
//     viol_cnt   out  per-channel counters, channel i at [i*CNT_W +: CNT_W]
//     state      out  IDLE=0, WARMUP=1, CHECK=2, FAULT=3
//
//   Build option
//     EXCL_MON_DEFERRED_ASSERT_EN : adds one final deferred assertion per
//     channel while checking. Port behaviour is the same with or without it.

module excl_monitor #(
  parameter int CH    = 4,
  parameter int DELAY = 1,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  clr,
  input  logic [CH-1:0]         a,
  input  logic [CH-1:0]         b,
  output logic [CH-1:0]         viol,
  output logic                  err,
  output logic                  first_vld,
  output logic [$clog2(CH)-1:0] first_ch,
  output logic [CH*CNT_W-1:0]   viol_cnt,
  output logic [1:0]            state
);

  localparam int FC_W = $clog2(CH);
  localparam int WC_W = (DELAY > 1) ? $clog2(DELAY) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_CHECK  = 2'd2,
    ST_FAULT  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_wc_load;
  logic [WC_W-1:0]   r_wcnt;
  logic [CH-1:0]     r_bd_pipe [DELAY];
  logic [CH-1:0]     w_bd;
  logic              w_qual;
  logic [CH-1:0]     w_raw;
  logic [FC_W-1:0]   w_low;
  logic [CNT_W-1:0]  r_cnt [CH];
  logic [CH-1:0]     r_viol;
  logic              r_err;
  logic              r_first_vld;
  logic [FC_W-1:0]   r_first_ch;

  // Delay line runs regardless of en/state so bd is always DELAY edges old.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DELAY; k++) r_bd_pipe[k] <= '0;
    end else begin
      r_bd_pipe[0] <= b;
      for (int k = 1; k < DELAY; k++) r_bd_pipe[k] <= r_bd_pipe[k-1];
    end
  end

  assign w_bd   = r_bd_pipe[DELAY-1];
  assign w_qual = (r_state == ST_CHECK) || (r_state == ST_FAULT);
  assign w_raw  = a & w_bd & {CH{w_qual}};

  // Descending scan leaves the lowest set index in w_low.
  always_comb begin
    w_low = '0;
    for (int i = CH - 1; i >= 0; i--) begin
      if (w_raw[i]) w_low = FC_W'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wc_load   = 1'b0;
    if (!en) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_WARMUP;
          w_wc_load   = 1'b1;
        end
        ST_WARMUP: if (r_wcnt == '0) w_state_nxt = ST_CHECK;
        // A violation coinciding with clr is discarded, so no FAULT then.
        ST_CHECK:  if (!clr && (|w_raw)) w_state_nxt = ST_FAULT;
        ST_FAULT:  if (clr) w_state_nxt = ST_CHECK;
        default:   w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Warm-up down-counter: loaded with DELAY-1 on entry, WARMUP ends at zero,
  // giving exactly DELAY cycles in WARMUP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wcnt <= '0;
    end else if (w_wc_load) begin
      r_wcnt <= WC_W'(DELAY - 1);
    end else if (r_state == ST_WARMUP && r_wcnt != '0) begin
      r_wcnt <= r_wcnt - WC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_viol      <= '0;
      r_err       <= 1'b0;
      r_first_vld <= 1'b0;
      r_first_ch  <= '0;
      for (int i = 0; i < CH; i++) r_cnt[i] <= '0;
    end else if (clr) begin
      r_viol      <= '0;
      r_err       <= 1'b0;
      r_first_vld <= 1'b0;
      r_first_ch  <= '0;
      for (int i = 0; i < CH; i++) r_cnt[i] <= '0;
    end else begin
      r_viol <= w_raw;
      if (|w_raw) r_err <= 1'b1;
      if ((|w_raw) && !r_first_vld) begin
        r_first_vld <= 1'b1;
        r_first_ch  <= w_low;
      end
      for (int i = 0; i < CH; i++) begin
        if (w_raw[i] && (r_cnt[i] != '1)) r_cnt[i] <= r_cnt[i] + CNT_W'(1);
      end
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_cnt_out
    assign viol_cnt[g*CNT_W +: CNT_W] = r_cnt[g];
  end

  assign viol      = r_viol;
  assign err       = r_err;
  assign first_vld = r_first_vld;
  assign first_ch  = r_first_ch;
  assign state     = r_state;

`ifdef EXCL_MON_DEFERRED_ASSERT_EN
  for (genvar g = 0; g < CH; g++) begin : g_excl_assert
    always_comb begin
      if (w_qual) begin
        a_excl: assert final (!(a[g] & w_bd[g]))
          $display("Pass");
        else
          $error("Fail ch=%0d", g);
      end
    end
  end
`endif

endmodule
